// File: rtl/margin_pkg.sv
// Shared types and the top-2 pair-merge used by every compare level of the margin pipeline.
package margin_pkg;

  localparam int unsigned PROB_W    = 8;
  localparam int unsigned N_CLASSES = 32;
  localparam int unsigned CLS_W     = 5;

  typedef struct packed {
    logic [PROB_W-1:0] max1;
    logic [CLS_W-1:0]  cls1;
    logic [PROB_W-1:0] max2;
  } top2_t;

  function automatic logic [PROB_W-1:0] max_prob(input logic [PROB_W-1:0] x,
                                                 input logic [PROB_W-1:0] y);
    return (x >= y) ? x : y;
  endfunction

  // a must carry the lower class indices so ">=" resolves ties toward the lowest class.
  function automatic top2_t merge_top2(input top2_t a, input top2_t b);
    top2_t r;
    if (a.max1 >= b.max1) begin
      r.max1 = a.max1;
      r.cls1 = a.cls1;
      r.max2 = max_prob(a.max2, b.max1);
    end else begin
      r.max1 = b.max1;
      r.cls1 = b.cls1;
      r.max2 = max_prob(a.max1, b.max2);
    end
    return r;
  endfunction

endpackage

// File: rtl/margin_pipeline_top2_group4.sv
// Combinational top-2 selector over one group of four consecutive classes.
module top2_group4
  import margin_pkg::*;
#(
  parameter int unsigned GROUP = 0
) (
  input  logic [4*PROB_W-1:0] probs,
  output top2_t               result
);

  top2_t leaf [4];

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      leaf[i].max1 = probs[i*PROB_W +: PROB_W];
      leaf[i].cls1 = CLS_W'(GROUP * 4 + i);
      leaf[i].max2 = '0;
    end
    result = merge_top2(merge_top2(leaf[0], leaf[1]), merge_top2(leaf[2], leaf[3]));
  end

endmodule

// File: rtl/margin_pipeline.sv
// Three-stage top-1/top-2 margin extractor: one 32-class sample per enabled cycle,
// tagged with a wrapping sample index, stalled by en and flushed by clr.
module margin_pipeline #(
  parameter int unsigned DATA_LENGTH = 4608,
  parameter int unsigned PROB_W      = 8,
  parameter int unsigned N_CLASSES   = 32,
  parameter int unsigned DEPTH       = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            clr,
  input  logic                            in_valid,
  input  logic [N_CLASSES*PROB_W-1:0]     in_data,
  output logic                            out_valid,
  output logic [PROB_W-1:0]               out_margin,
  output logic [$clog2(DATA_LENGTH)-1:0]  out_index,
  output logic [margin_pkg::CLS_W-1:0]    out_class
);
  import margin_pkg::top2_t;
  import margin_pkg::merge_top2;
  import margin_pkg::CLS_W;

  localparam int unsigned IDX_W    = $clog2(DATA_LENGTH);
  localparam int unsigned N_GROUPS = N_CLASSES / 4;

  top2_t             grpComb [N_GROUPS];
  top2_t             s1Top   [N_GROUPS];
  top2_t             s2ANext, s2BNext, s3Merge;
  top2_t             s2A, s2B;
  logic [PROB_W-1:0] marginQ;
  logic [CLS_W-1:0]  classQ;
  logic [DEPTH-1:0]  vPipe;
  logic [IDX_W-1:0]  idxPipe [DEPTH];
  logic [IDX_W-1:0]  idxCnt;
  logic [IDX_W-1:0]  idxNext;

  for (genvar g = 0; g < N_GROUPS; g++) begin : g_group
    top2_group4 #(.GROUP(g)) u_group (
      .probs  (in_data[g*4*PROB_W +: 4*PROB_W]),
      .result (grpComb[g])
    );
  end

  always_comb begin
    s2ANext = merge_top2(merge_top2(s1Top[0], s1Top[1]), merge_top2(s1Top[2], s1Top[3]));
    s2BNext = merge_top2(merge_top2(s1Top[4], s1Top[5]), merge_top2(s1Top[6], s1Top[7]));
    s3Merge = merge_top2(s2A, s2B);
    idxNext = (idxCnt == IDX_W'(DATA_LENGTH - 1)) ? '0 : idxCnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_GROUPS; i++) s1Top[i] <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) idxPipe[i] <= '0;
      s2A     <= '0;
      s2B     <= '0;
      marginQ <= '0;
      classQ  <= '0;
      vPipe   <= '0;
      idxCnt  <= '0;
    end else begin
      if (en) begin
        s1Top      <= grpComb;
        s2A        <= s2ANext;
        s2B        <= s2BNext;
        marginQ    <= s3Merge.max1 - s3Merge.max2;
        classQ     <= s3Merge.cls1;
        vPipe      <= {vPipe[DEPTH-2:0], in_valid};
        idxPipe[0] <= idxCnt;
        for (int unsigned i = 1; i < DEPTH; i++) idxPipe[i] <= idxPipe[i-1];
        if (in_valid) idxCnt <= idxNext;
      end
      // clr overrides the enabled update above, discarding any coincident sample.
      if (clr) begin
        vPipe  <= '0;
        idxCnt <= '0;
      end
    end
  end

  assign out_valid  = vPipe[DEPTH-1];
  assign out_margin = marginQ;
  assign out_class  = classQ;
  assign out_index  = idxPipe[DEPTH-1];

endmodule
